// File: rtl/el2_dec_nb_scoreboard.sv
// Decode-stage scoreboard for long-latency writes (non-blocking loads, divides).
// Grants tags, flags RAW hazards, and turns returns into a registered GPR write port.
module el2_dec_nb_sb_entry (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       flush_i,
  input  logic       alloc_i,
  input  logic [4:0] alloc_rd_i,
  input  logic       wpend_set_i,
  input  logic       clr_i,
  output logic       valid_o,
  output logic       valid_d_o,
  output logic       wpend_o,
  output logic [4:0] rd_o
);
  logic       valid_q, valid_d, wpend_q, wpend_d;
  logic [4:0] rd_q, rd_d;

  always_comb begin
    valid_d = valid_q;
    wpend_d = wpend_q;
    rd_d    = rd_q;
    if (clr_i) begin
      valid_d = 1'b0;
      wpend_d = 1'b0;
    end
    if (wpend_set_i) wpend_d = 1'b1;
    if (flush_i) begin
      valid_d = 1'b0;
      wpend_d = 1'b0;
    end
    // alloc only targets entries free at cycle start, so it never races clr/wpend_set
    if (alloc_i) begin
      valid_d = 1'b1;
      wpend_d = 1'b0;
      rd_d    = alloc_rd_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      valid_q <= 1'b0;
      wpend_q <= 1'b0;
      rd_q    <= 5'd0;
    end else begin
      valid_q <= valid_d;
      wpend_q <= wpend_d;
      rd_q    <= rd_d;
    end
  end

  assign valid_o   = valid_q;
  assign valid_d_o = rst_l & valid_d;
  assign wpend_o   = wpend_q;
  assign rd_o      = rd_q;
endmodule

module el2_dec_nb_scoreboard #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       flush,
  input  logic                       alloc_valid,
  input  logic [4:0]                 alloc_rd,
  output logic                       alloc_ready,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic                       ret_valid,
  input  logic [TAG_W-1:0]           ret_tag,
  input  logic                       ret_kill,
  input  logic [31:0]                ret_data,
  input  logic [4:0]                 raddr0,
  input  logic [4:0]                 raddr1,
  output logic                       raw_hazard,
  output logic                       gpr_wen,
  output logic [4:0]                 gpr_waddr,
  output logic [31:0]                gpr_wd,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       stray_ret
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]      valid_q, valid_d, wpend_q;
  logic [DEPTH-1:0][4:0] rd_q;
  logic [DEPTH-1:0]      alloc_sel, wpend_set, clr, ret_sel, waw_hit, raw_hit;
  logic [DEPTH-1:0]      wsel_q;
  logic                  any_free, alloc_fire, ret_hit, ret_acc, no_write, wr_d;
  logic [TAG_W-1:0]      free_tag;
  logic [4:0]            ret_rd;
  logic [CNT_W-1:0]      cnt_d, outstanding_q;
  logic                  gpr_wen_q, stray_q;
  logic [4:0]            gpr_waddr_q;
  logic [31:0]           gpr_wd_q;

  always_comb begin
    any_free = 1'b0;
    free_tag = '0;
    ret_rd   = 5'd0;
    cnt_d    = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_tag = TAG_W'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      ret_sel[i] = (ret_tag == TAG_W'(i));
      waw_hit[i] = valid_q[i] & (alloc_rd != 5'd0) & (rd_q[i] == alloc_rd);
      raw_hit[i] = valid_q[i] & (rd_q[i] != 5'd0) &
                   ((rd_q[i] == raddr0) | (rd_q[i] == raddr1));
      if (ret_sel[i]) ret_rd = rd_q[i];
      cnt_d = cnt_d + CNT_W'(valid_d[i]);
    end
  end

  assign alloc_ready = ~flush & any_free & ~(|waw_hit);
  assign alloc_tag   = free_tag;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign raw_hazard  = |raw_hit;
  // a tag beyond DEPTH selects nothing and so counts as stray
  assign ret_hit     = |(ret_sel & valid_q & ~wpend_q);
  assign ret_acc     = ret_valid & ~flush & ret_hit;
  assign no_write    = ret_kill | (ret_rd == 5'd0);
  assign wr_d        = ret_acc & ~no_write;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign alloc_sel[g] = alloc_fire & (free_tag == TAG_W'(g));
    assign wpend_set[g] = wr_d & ret_sel[g];
    // gating on wpend keeps a post-flush write from freeing a freshly granted entry
    assign clr[g] = (ret_acc & no_write & ret_sel[g]) |
                    (gpr_wen_q & wsel_q[g] & wpend_q[g]);
    el2_dec_nb_sb_entry u_ent (
      .clk         (clk),
      .rst_l       (rst_l),
      .flush_i     (flush),
      .alloc_i     (alloc_sel[g]),
      .alloc_rd_i  (alloc_rd),
      .wpend_set_i (wpend_set[g]),
      .clr_i       (clr[g]),
      .valid_o     (valid_q[g]),
      .valid_d_o   (valid_d[g]),
      .wpend_o     (wpend_q[g]),
      .rd_o        (rd_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      gpr_wen_q     <= 1'b0;
      gpr_waddr_q   <= 5'd0;
      gpr_wd_q      <= 32'd0;
      wsel_q        <= '0;
      stray_q       <= 1'b0;
      outstanding_q <= '0;
    end else begin
      gpr_wen_q     <= wr_d;
      stray_q       <= ret_valid & ~flush & ~ret_hit;
      outstanding_q <= cnt_d;
      if (wr_d) begin
        gpr_waddr_q <= ret_rd;
        gpr_wd_q    <= ret_data;
        wsel_q      <= ret_sel;
      end
    end
  end

  assign gpr_wen     = gpr_wen_q;
  assign gpr_waddr   = gpr_waddr_q;
  assign gpr_wd      = gpr_wd_q;
  assign stray_ret   = stray_q;
  assign outstanding = outstanding_q;
endmodule
